// File: rtl/pkg_dift.sv
// Constants shared by the DIFT tag-init engine and the tag-override stage.
package pkg_dift;
  localparam int unsigned TAG_BITS_NUM = 4;
  localparam int unsigned TAG_LSB      = 32;
endpackage

// File: rtl/dift_tag_init_engine.sv
// Sweeps a word-aligned TCDM range, rewriting tag bits [35:32] of each word
// by read-modify-write while preserving data bits [31:0].
module dift_tag_init_engine
  import pkg_dift::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_BITS   = TAG_BITS_NUM,
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH - 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [ADDR_WIDTH-1:0]        start_addr_i,
  input  logic [ADDR_WIDTH-1:0]        end_addr_i,
  input  logic [TAG_BITS-1:0]          tag_value_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         aborted_o,
  output logic [CNT_WIDTH-1:0]         words_done_o,
  output logic                         tcdm_req_o,
  output logic [ADDR_WIDTH-1:0]        tcdm_add_o,
  output logic                         tcdm_wen_o,
  output logic [3:0]                   tcdm_be_o,
  output logic [TAG_LSB+TAG_BITS-1:0]  tcdm_wdata_o,
  input  logic                         tcdm_gnt_i,
  input  logic                         tcdm_r_valid_i,
  input  logic [TAG_LSB+TAG_BITS-1:0]  tcdm_r_rdata_i,
  input  logic                         tcdm_r_opc_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_cur;
  logic [ADDR_WIDTH-1:0]   r_end;
  logic [TAG_BITS-1:0]     r_tag;
  logic [TAG_LSB-1:0]      r_data;
  logic                    r_err;
  logic                    r_aborted;
  logic [CNT_WIDTH-1:0]    r_words;
  logic                    w_bad;
  logic                    w_last;
  logic                    w_unused_rtag;

  // Incoming tag bits are replaced, never merged.
  assign w_unused_rtag = ^tcdm_r_rdata_i[TAG_LSB+TAG_BITS-1:TAG_LSB];

  assign w_bad = (start_addr_i[1:0] != 2'b00) || (end_addr_i[1:0] != 2'b00) ||
                 (end_addr_i <= start_addr_i);
  // Compared before the increment so the range end never has to wrap.
  assign w_last = ((r_cur + ADDR_WIDTH'(4)) == r_end);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_next = w_bad ? FINISH : RD_REQ;
      RD_REQ:  if (tcdm_gnt_i) w_next = RD_WAIT;
      RD_WAIT: if (tcdm_r_valid_i) w_next = tcdm_r_opc_i ? FINISH : WR_REQ;
      WR_REQ:  if (tcdm_gnt_i) w_next = WR_WAIT;
      WR_WAIT: begin
        if (tcdm_r_valid_i) begin
          if (tcdm_r_opc_i || w_last || abort_i) w_next = FINISH;
          else                                    w_next = RD_REQ;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur     <= '0;
      r_end     <= '0;
      r_tag     <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      r_words   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cur     <= start_addr_i;
            r_end     <= end_addr_i;
            r_tag     <= tag_value_i;
            r_err     <= w_bad;
            r_aborted <= 1'b0;
            r_words   <= '0;
          end
        end
        RD_WAIT: begin
          if (tcdm_r_valid_i) begin
            r_data <= tcdm_r_rdata_i[TAG_LSB-1:0];
            if (tcdm_r_opc_i) r_err <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (tcdm_r_valid_i) begin
            if (tcdm_r_opc_i) begin
              r_err <= 1'b1;
            end else begin
              r_words <= r_words + 1'b1;
              r_cur   <= r_cur + ADDR_WIDTH'(4);
              if (abort_i) r_aborted <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o       = (r_state != IDLE);
    done_o       = (r_state == FINISH);
    tcdm_req_o   = (r_state == RD_REQ) || (r_state == WR_REQ);
    tcdm_wen_o   = (r_state == RD_REQ);
    tcdm_be_o    = tcdm_req_o ? 4'hF : 4'h0;
    tcdm_add_o   = r_cur;
    tcdm_wdata_o = {r_tag, r_data};
    err_o        = r_err;
    aborted_o    = r_aborted;
    words_done_o = r_words;
  end

endmodule

// File: tb/tb_dift_tag_init_engine.sv
// Self-checking bench: TCDM slave model with configurable latency and a
// queue of expected write transactions.
module tb_dift_tag_init_engine;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] start_addr_i = '0;
  logic [31:0] end_addr_i = '0;
  logic [3:0]  tag_value_i = '0;
  logic        busy_o, done_o, err_o, aborted_o;
  logic [29:0] words_done_o;
  logic        tcdm_req_o, tcdm_wen_o;
  logic [31:0] tcdm_add_o;
  logic [3:0]  tcdm_be_o;
  logic [35:0] tcdm_wdata_o;
  logic        tcdm_gnt_i = 1'b0;
  logic        tcdm_r_valid_i = 1'b0;
  logic [35:0] tcdm_r_rdata_i = '0;
  logic        tcdm_r_opc_i = 1'b0;

  dift_tag_init_engine #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .tag_value_i(tag_value_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .aborted_o(aborted_o),
    .words_done_o(words_done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
    .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_rdata_i(tcdm_r_rdata_i), .tcdm_r_opc_i(tcdm_r_opc_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [35:0] d;
  } exp_t;
  exp_t exp_q[$];

  logic [35:0] mem [8];
  int cyc = 0;
  int gnt_dly = 0, rv_dly = 0, opc_rd_n = 0;
  int rd_cnt = 0, wr_cnt = 0;
  int first_req_cyc = -1, done_cyc = -1, done_seen = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_i && tcdm_req_o && first_req_cyc < 0) first_req_cyc = cyc;
    if (done_o) begin
      done_seen++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] dval(input int i);
    return 32'hC0DE_0000 ^ (32'h0101_0101 * (i + 1));
  endfunction

  // Slave model: grants after gnt_dly wait cycles, responds rv_dly cycles later.
  bit          pend = 0, holding = 0, pend_opc = 0;
  int          gcnt = 0, rcnt = 0;
  logic [35:0] pend_data = '0;
  logic [72:0] hold = '0;

  task automatic do_access();
    int   idx;
    exp_t e;
    idx = int'((tcdm_add_o - BASE) >> 2);
    check("addr_in_range", 80'(idx >= 0 && idx < 8), 80'd1);
    if (idx < 0 || idx >= 8) idx = 0;
    if (tcdm_wen_o) begin
      rd_cnt++;
      pend_data = mem[idx];
      pend_opc  = (rd_cnt == opc_rd_n);
    end else begin
      wr_cnt++;
      pend_data = '0;
      pend_opc  = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 80'(tcdm_add_o), 80'hFFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 80'(tcdm_add_o), 80'(e.a));
        check("wr_data", 80'(tcdm_wdata_o), 80'(e.d));
      end
      mem[idx] = tcdm_wdata_o;
    end
  endtask

  always begin
    @(negedge clk);
    if (rst_i) begin
      tcdm_gnt_i = 0; tcdm_r_valid_i = 0; tcdm_r_opc_i = 0;
      pend = 0; gcnt = 0; holding = 0;
    end else begin
      tcdm_r_valid_i = 0;
      tcdm_r_opc_i = 0;
      if (tcdm_gnt_i) begin
        tcdm_gnt_i = 0;
        pend = 1;
        rcnt = rv_dly;
      end else if (tcdm_req_o && !pend) begin
        if (!holding) begin
          hold = {tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_wdata_o};
          holding = 1;
        end else begin
          check("req_stable", 80'({tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_wdata_o}), 80'(hold));
        end
        if (gcnt == gnt_dly) begin
          tcdm_gnt_i = 1;
          gcnt = 0;
          holding = 0;
          check("req_be", 80'(tcdm_be_o), 80'hF);
          do_access();
        end else begin
          gcnt++;
        end
      end
      if (pend) begin
        if (rcnt == 0) begin
          tcdm_r_valid_i = 1;
          tcdm_r_rdata_i = pend_data;
          tcdm_r_opc_i   = pend_opc;
          pend = 0;
        end else begin
          rcnt--;
        end
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < 8; i++) mem[i] = {4'h0, dval(i)};
  endtask

  task automatic push_words(input int n, input logic [3:0] tag);
    for (int i = 0; i < n; i++) exp_q.push_back('{a: BASE + 32'(4 * i), d: {tag, dval(i)}});
  endtask

  int s_cyc;
  task automatic start_sweep(input logic [31:0] sa, input logic [31:0] ea, input logic [3:0] tag);
    rd_cnt = 0; wr_cnt = 0; done_seen = 0; first_req_cyc = -1; done_cyc = -1;
    @(negedge clk);
    start_addr_i = sa; end_addr_i = ea; tag_value_i = tag; start_i = 1;
    s_cyc = cyc;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_seen > 0) break;
    end
    if (k == budget) check("done_timeout", 80'd0, 80'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_mem(input string tag, input int i, input logic [35:0] exp);
    check(tag, 80'(mem[i]), 80'(exp));
  endtask

  initial begin
    preload();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 80'(busy_o), 80'd0);
    check("rst_done", 80'(done_o), 80'd0);
    check("rst_err", 80'(err_o), 80'd0);
    check("rst_aborted", 80'(aborted_o), 80'd0);
    check("rst_words", 80'(words_done_o), 80'd0);
    check("rst_req", 80'(tcdm_req_o), 80'd0);
    @(negedge clk); rst_i = 0;

    // Zero-wait 4-word sweep
    push_words(4, 4'hA);
    start_sweep(BASE, BASE + 32'h10, 4'hA);
    wait_done(200);
    check("t1_done_latency", 80'(done_cyc - first_req_cyc), 80'd16);
    check("t1_words", 80'(words_done_o), 80'd4);
    check("t1_err", 80'(err_o), 80'd0);
    check("t1_reqs", 80'(rd_cnt + wr_cnt), 80'd8);
    check("t1_busy", 80'(busy_o), 80'd0);
    check("t1_done_pulses", 80'(done_seen), 80'd1);
    for (int i = 0; i < 4; i++) check_mem("t1_mem", i, {4'hA, dval(i)});
    check_mem("t1_mem_beyond", 4, {4'h0, dval(4)});
    check("t1_q_empty", 80'(exp_q.size()), 80'd0);

    // Delayed grant and response
    preload();
    gnt_dly = 3; rv_dly = 2;
    push_words(4, 4'hA);
    start_sweep(BASE, BASE + 32'h10, 4'hA);
    wait_done(400);
    check("t2_words", 80'(words_done_o), 80'd4);
    check("t2_reqs", 80'(rd_cnt + wr_cnt), 80'd8);
    for (int i = 0; i < 4; i++) check_mem("t2_mem", i, {4'hA, dval(i)});
    check("t2_q_empty", 80'(exp_q.size()), 80'd0);
    gnt_dly = 0; rv_dly = 0;

    // Rejected starts: misaligned, then empty range
    start_sweep(BASE + 32'h2, BASE + 32'h10, 4'h3);
    wait_done(20);
    check("t3_done_cyc", 80'(done_cyc - s_cyc), 80'd1);
    check("t3_err", 80'(err_o), 80'd1);
    check("t3_words", 80'(words_done_o), 80'd0);
    check("t3_reqs", 80'(rd_cnt + wr_cnt + (first_req_cyc >= 0 ? 1 : 0)), 80'd0);
    start_sweep(BASE, BASE, 4'h3);
    wait_done(20);
    check("t3b_done_cyc", 80'(done_cyc - s_cyc), 80'd1);
    check("t3b_err", 80'(err_o), 80'd1);
    check("t3b_reqs", 80'(rd_cnt + wr_cnt + (first_req_cyc >= 0 ? 1 : 0)), 80'd0);

    // Abort during word 2
    preload();
    push_words(2, 4'hA);
    start_sweep(BASE, BASE + 32'h10, 4'hA);
    for (int k = 0; k < 100 && rd_cnt < 2; k++) begin
      @(posedge clk); #1;
    end
    abort_i = 1;
    wait_done(200);
    abort_i = 0;
    check("t4_done", 80'(done_seen), 80'd1);
    check("t4_aborted", 80'(aborted_o), 80'd1);
    check("t4_err", 80'(err_o), 80'd0);
    check("t4_words", 80'(words_done_o), 80'd2);
    check_mem("t4_mem1", 1, {4'hA, dval(1)});
    check_mem("t4_mem2", 2, {4'h0, dval(2)});
    check_mem("t4_mem3", 3, {4'h0, dval(3)});
    check("t4_q_empty", 80'(exp_q.size()), 80'd0);

    // Error response on third read
    preload();
    opc_rd_n = 3;
    push_words(2, 4'h6);
    start_sweep(BASE, BASE + 32'h10, 4'h6);
    wait_done(200);
    opc_rd_n = 0;
    check("t5_done", 80'(done_seen), 80'd1);
    check("t5_err", 80'(err_o), 80'd1);
    check("t5_aborted", 80'(aborted_o), 80'd0);
    check("t5_words", 80'(words_done_o), 80'd2);
    check("t5_writes", 80'(wr_cnt), 80'd2);
    check_mem("t5_mem2", 2, {4'h0, dval(2)});
    check("t5_q_empty", 80'(exp_q.size()), 80'd0);

    // Asynchronous reset while a write request is pending
    preload();
    gnt_dly = 20;
    push_words(1, 4'h9);
    start_sweep(BASE, BASE + 32'h10, 4'h9);
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (tcdm_req_o && !tcdm_wen_o) break;
      end
      if (k == 200) check("t6_wr_req_timeout", 80'd0, 80'd1);
    end
    #2 rst_i = 1;
    #1;
    check("t6_req_drop", 80'(tcdm_req_o), 80'd0);
    check("t6_busy_drop", 80'(busy_o), 80'd0);
    @(negedge clk); @(negedge clk);
    rst_i = 0;
    gnt_dly = 0;
    exp_q.delete();
    preload();
    push_words(4, 4'h5);
    start_sweep(BASE, BASE + 32'h10, 4'h5);
    wait_done(200);
    check("t6_words", 80'(words_done_o), 80'd4);
    check("t6_err", 80'(err_o), 80'd0);
    for (int i = 0; i < 4; i++) check_mem("t6_mem", i, {4'h5, dval(i)});
    check("t6_q_empty", 80'(exp_q.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
